// File: rtl/autocorr.sv
// Frame autocorrelation engine: one time-multiplexed MAC accumulates lags R[0..10]
// over N Q15 samples, then block-normalises so R0 fits 16 bits.
module autocorr #(
    parameter int N     = 160,
    parameter int ACC_W = 40
) (
    input  logic               clk,
    input  logic               rst,
    input  logic signed [15:0] x,
    input  logic               x_valid,
    output logic               x_ready,
    output logic signed [15:0] R0,
    output logic signed [15:0] R1,
    output logic signed [15:0] R2,
    output logic signed [15:0] R3,
    output logic signed [15:0] R4,
    output logic signed [15:0] R5,
    output logic signed [15:0] R6,
    output logic signed [15:0] R7,
    output logic signed [15:0] R8,
    output logic signed [15:0] R9,
    output logic signed [15:0] R10,
    output logic [4:0]         norm_shift,
    output logic               done
);
    localparam int          CNT_W = $clog2(N + 1);
    localparam int unsigned S_MAX = ACC_W - 16;
    localparam logic signed [ACC_W-1:0] Q_MAX = ACC_W'(32767);
    localparam logic signed [ACC_W-1:0] Q_MIN = ~Q_MAX;

    typedef enum logic [1:0] {ACCEPT, MAC, NORM, OUT} state_t;
    state_t state, state_nx;

    logic signed [15:0]      cur;
    logic signed [15:0]      dly [1:10];
    logic signed [ACC_W-1:0] acc [0:10];
    logic [3:0]              k;
    logic [CNT_W-1:0]        cnt;
    logic [4:0]              s_q;
    logic [4:0]              s_nx;
    logic                    s_found;
    logic signed [15:0]      r_q  [0:10];
    logic signed [15:0]      r_nx [0:10];
    logic signed [ACC_W-1:0] shifted [0:10];
    logic signed [15:0]      opnd;
    logic signed [31:0]      prod;
    logic signed [ACC_W-1:0] prod_ext;
    logic                    accept;
    logic                    mac_last;
    logic                    frame_full;

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= ACCEPT;
        else      state <= state_nx;
    end

    assign mac_last   = (state == MAC) && (k == 4'd10);
    assign frame_full = (cnt == CNT_W'(N - 1));

    // Next-state logic
    always_comb begin
        state_nx = state;
        case (state)
            ACCEPT:  if (accept) state_nx = MAC;
            MAC:     if (mac_last) state_nx = frame_full ? NORM : ACCEPT;
            NORM:    state_nx = OUT;
            OUT:     state_nx = ACCEPT;
            default: state_nx = ACCEPT;
        endcase
    end

    // Output logic; ready is held low for as long as reset is asserted
    always_comb begin
        x_ready = (state == ACCEPT) && rst;
        accept  = x_valid && x_ready;
    end

    // Lag operand: k==0 squares the current sample, k>0 reaches back k samples
    always_comb begin
        opnd = cur;
        for (int unsigned i = 1; i <= 10; i++)
            if (k == 4'(i)) opnd = dly[i];
    end

    assign prod     = cur * opnd;
    assign prod_ext = {{(ACC_W - 32){prod[31]}}, prod};

    // Smallest shift bringing R0 into 16 bits; R0 is a sum of squares, never negative
    always_comb begin
        s_nx    = 5'(S_MAX);
        s_found = 1'b0;
        for (int unsigned i = 0; i <= S_MAX; i++) begin
            if (!s_found && ((acc[0] >>> i) <= Q_MAX)) begin
                s_nx    = 5'(i);
                s_found = 1'b1;
            end
        end
    end

    always_comb begin
        for (int unsigned i = 0; i < 11; i++) begin
            shifted[i] = acc[i] >>> s_q;
            if (shifted[i] > Q_MAX)
                r_nx[i] = 16'sh7fff;
            else if (shifted[i] < Q_MIN)
                r_nx[i] = -16'sh8000;
            else
                r_nx[i] = shifted[i][15:0];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cur        <= '0;
            k          <= '0;
            cnt        <= '0;
            s_q        <= '0;
            norm_shift <= '0;
            done       <= 1'b0;
            for (int unsigned i = 1; i <= 10; i++) dly[i] <= '0;
            for (int unsigned i = 0; i < 11; i++) begin
                acc[i] <= '0;
                r_q[i] <= '0;
            end
        end else begin
            done <= 1'b0;
            case (state)
                ACCEPT: begin
                    if (accept) begin
                        cur <= x;
                        k   <= '0;
                    end
                end
                MAC: begin
                    for (int unsigned i = 0; i < 11; i++)
                        if (k == 4'(i)) acc[i] <= acc[i] + prod_ext;
                    k <= k + 4'd1;
                    if (mac_last) begin
                        dly[1] <= cur;
                        for (int unsigned i = 2; i <= 10; i++) dly[i] <= dly[i-1];
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                NORM: s_q <= s_nx;
                OUT: begin
                    for (int unsigned i = 0; i < 11; i++) begin
                        r_q[i] <= r_nx[i];
                        acc[i] <= '0;
                    end
                    for (int unsigned i = 1; i <= 10; i++) dly[i] <= '0;
                    cnt        <= '0;
                    norm_shift <= s_q;
                    done       <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign R0  = r_q[0];
    assign R1  = r_q[1];
    assign R2  = r_q[2];
    assign R3  = r_q[3];
    assign R4  = r_q[4];
    assign R5  = r_q[5];
    assign R6  = r_q[6];
    assign R7  = r_q[7];
    assign R8  = r_q[8];
    assign R9  = r_q[9];
    assign R10 = r_q[10];

endmodule

// File: tb/tb_autocorr.sv
// Bench for autocorr: random and directed frames checked against a plain-arithmetic
// autocorrelation model.
module tb_autocorr;
    localparam int N     = 160;
    localparam int ACC_W = 40;

    logic               clk = 1'b0;
    logic               rst = 1'b0;
    logic signed [15:0] x = '0;
    logic               x_valid = 1'b0;
    logic               x_ready;
    logic               done;
    logic signed [15:0] R0, R1, R2, R3, R4, R5, R6, R7, R8, R9, R10;
    logic [4:0]         norm_shift;
    logic [175:0]       r_all;

    int nvec = 0;
    int nbad = 0;
    int cyc  = 0;
    int frame [0:N-1];
    int exp_r [0:10];
    int exp_s;
    int first_acc;
    int last_acc;

    logic [175:0] q_r [$];
    int           q_s [$];
    int           q_cyc [$];

    autocorr #(.N(N), .ACC_W(ACC_W)) dut (
        .clk(clk), .rst(rst), .x(x), .x_valid(x_valid), .x_ready(x_ready),
        .R0(R0), .R1(R1), .R2(R2), .R3(R3), .R4(R4), .R5(R5), .R6(R6),
        .R7(R7), .R8(R8), .R9(R9), .R10(R10),
        .norm_shift(norm_shift), .done(done)
    );

    assign r_all = {R10, R9, R8, R7, R6, R5, R4, R3, R2, R1, R0};

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (done === 1'b1) begin
            q_r.push_back(r_all);
            q_s.push_back(int'(norm_shift));
            q_cyc.push_back(cyc);
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL global_timeout: simulation still running at %0t, required finish", $time);
        $fatal(1);
    end

    // Direct evaluation of R[k] = sum x[n]x[n-k], then normalisation and clamping
    function automatic void model(input int len);
        longint a [0:10];
        longint v;
        bit     found;
        for (int k = 0; k < 11; k++) begin
            a[k] = 0;
            for (int n = k; n < len; n++) a[k] += longint'(frame[n]) * longint'(frame[n-k]);
        end
        exp_s = ACC_W - 16;
        found = 1'b0;
        for (int s = 0; s <= ACC_W - 16; s++) begin
            if (!found && ((a[0] >>> s) <= 32767)) begin
                exp_s = s;
                found = 1'b1;
            end
        end
        for (int k = 0; k < 11; k++) begin
            v = a[k] >>> exp_s;
            if (v > 32767) v = 32767;
            else if (v < -32768) v = -32768;
            exp_r[k] = int'(v);
        end
    endfunction

    task automatic send_frame(input int len, input int gap_pct);
        int waited;
        bit taken;
        for (int n = 0; n < len; n++) begin
            waited = 0;
            taken  = 1'b0;
            x = 16'(frame[n]);
            while (!taken) begin
                x_valid = ($urandom_range(99) >= gap_pct);
                if (x_valid && (x_ready === 1'b1)) begin
                    taken = 1'b1;
                    if (n == 0) first_acc = cyc;
                    last_acc = cyc;
                end
                @(negedge clk);
                waited++;
                if (!taken && waited > 400) begin
                    nvec++;
                    nbad++;
                    $display("FAIL accept_timeout: sample %0d x_ready=%b, required 1 within 400 cycles", n, x_ready);
                    x_valid = 1'b0;
                    return;
                end
            end
        end
        x_valid = 1'b0;
    endtask

    task automatic wait_done(input int base, input int budget);
        for (int w = 0; w < budget && q_s.size() <= base; w++) @(posedge clk);
        @(negedge clk);
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset;
        rst = 1'b0;
        x_valid = 1'b1;
        x = 16'sd1234;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            nvec++; if (x_ready !== 1'b0) begin nbad++; $display("FAIL reset_x_ready: got %b required 0", x_ready); end
            nvec++; if (done !== 1'b0) begin nbad++; $display("FAIL reset_done: got %b required 0", done); end
            nvec++; if (norm_shift !== 5'd0) begin nbad++; $display("FAIL reset_norm_shift: got %0d required 0", norm_shift); end
            nvec++; if (r_all !== '0) begin nbad++; $display("FAIL reset_R: got %h required 0", r_all); end
        end
        rst = 1'b1;
        x_valid = 1'b0;
        #1;
        nvec++; if (x_ready !== 1'b1) begin nbad++; $display("FAIL reset_release_ready: got %b required 1", x_ready); end
        @(negedge clk);
    endtask

    task automatic test_constant;
        int base;
        logic [175:0] rv;
        logic signed [15:0] g;
        base = q_s.size();
        for (int n = 0; n < N; n++) frame[n] = 16384;
        model(N);
        send_frame(N, 0);
        wait_done(base, 40);
        nvec++;
        if (q_s.size() != base + 1) begin
            nbad++; $display("FAIL const_done_count: got %0d pulses required 1", q_s.size() - base);
        end else begin
            rv = q_r[base];
            nvec++; if (q_cyc[base] - last_acc != 14) begin nbad++; $display("FAIL const_latency: got %0d cycles required 14", q_cyc[base] - last_acc); end
            nvec++; if (q_s[base] != 21) begin nbad++; $display("FAIL const_norm_shift: got %0d required 21", q_s[base]); end
            nvec++; if (rv[15:0] !== 16'sd20480) begin nbad++; $display("FAIL const_R0_literal: got %0d required 20480", $signed(rv[15:0])); end
            nvec++; if (rv[175:160] !== 16'sd19200) begin nbad++; $display("FAIL const_R10_literal: got %0d required 19200", $signed(rv[175:160])); end
            for (int k = 0; k < 11; k++) begin
                g = rv[k*16 +: 16];
                nvec++;
                if (int'(g) != exp_r[k] || int'(g) != (160 - k) * 128) begin
                    nbad++; $display("FAIL const_R%0d: got %0d required %0d", k, g, (160 - k) * 128);
                end
            end
        end
    endtask

    task automatic test_impulse;
        int base;
        logic [175:0] rv;
        logic signed [15:0] g;
        base = q_s.size();
        for (int n = 0; n < N; n++) frame[n] = 0;
        frame[0] = 32767;
        model(N);
        send_frame(N, 0);
        wait_done(base, 40);
        nvec++;
        if (q_s.size() != base + 1) begin
            nbad++; $display("FAIL impulse_done_count: got %0d pulses required 1", q_s.size() - base);
        end else begin
            rv = q_r[base];
            nvec++; if (q_s[base] != 15 || q_s[base] != exp_s) begin nbad++; $display("FAIL impulse_norm_shift: got %0d required 15", q_s[base]); end
            nvec++; if (rv[15:0] !== 16'sd32766) begin nbad++; $display("FAIL impulse_R0_literal: got %0d required 32766", $signed(rv[15:0])); end
            for (int k = 1; k < 11; k++) begin
                g = rv[k*16 +: 16];
                nvec++;
                if (int'(g) != exp_r[k]) begin nbad++; $display("FAIL impulse_R%0d: got %0d required %0d", k, g, exp_r[k]); end
            end
        end
    endtask

    task automatic test_alternating;
        int base;
        logic [175:0] rv;
        logic signed [15:0] g;
        base = q_s.size();
        for (int n = 0; n < N; n++) frame[n] = (n % 2 == 0) ? 16384 : -16384;
        model(N);
        send_frame(N, 0);
        wait_done(base, 40);
        nvec++;
        if (q_s.size() != base + 1) begin
            nbad++; $display("FAIL alt_done_count: got %0d pulses required 1", q_s.size() - base);
        end else begin
            rv = q_r[base];
            nvec++; if (q_s[base] != 21) begin nbad++; $display("FAIL alt_norm_shift: got %0d required 21", q_s[base]); end
            nvec++; if (rv[31:16] !== -16'sd20352) begin nbad++; $display("FAIL alt_R1_literal: got %0d required -20352", $signed(rv[31:16])); end
            nvec++; if (rv[47:32] !== 16'sd20224) begin nbad++; $display("FAIL alt_R2_literal: got %0d required 20224", $signed(rv[47:32])); end
            for (int k = 0; k < 11; k++) begin
                g = rv[k*16 +: 16];
                nvec++;
                if (int'(g) != exp_r[k]) begin nbad++; $display("FAIL alt_R%0d: got %0d required %0d", k, g, exp_r[k]); end
            end
        end
    endtask

    task automatic test_back_to_back;
        int base;
        logic [175:0] rv;
        logic signed [15:0] g;
        base = q_s.size();
        for (int n = 0; n < N; n++) frame[n] = 0;
        send_frame(N, 0);
        for (int n = 0; n < N; n++) frame[n] = 16384;
        model(N);
        send_frame(N, 0);
        nvec++;
        if (q_s.size() < base + 1) begin
            nbad++; $display("FAIL b2b_silence_done: got %0d pulses required 1", q_s.size() - base);
        end else begin
            nvec++; if (q_s[base] != 0) begin nbad++; $display("FAIL b2b_silence_shift: got %0d required 0", q_s[base]); end
            nvec++; if (q_r[base] !== '0) begin nbad++; $display("FAIL b2b_silence_R: got %h required 0", q_r[base]); end
            nvec++; if (first_acc != q_cyc[base]) begin nbad++; $display("FAIL b2b_accept_cycle: got %0d required %0d", first_acc, q_cyc[base]); end
        end
        wait_done(base + 1, 40);
        nvec++;
        if (q_s.size() != base + 2) begin
            nbad++; $display("FAIL b2b_const_done: got %0d pulses required 2", q_s.size() - base);
        end else begin
            rv = q_r[base + 1];
            nvec++; if (q_s[base + 1] != 21) begin nbad++; $display("FAIL b2b_const_shift: got %0d required 21", q_s[base + 1]); end
            for (int k = 0; k < 11; k++) begin
                g = rv[k*16 +: 16];
                nvec++;
                if (int'(g) != (160 - k) * 128) begin nbad++; $display("FAIL b2b_const_R%0d: got %0d required %0d", k, g, (160 - k) * 128); end
            end
        end
    endtask

    task automatic test_random_backpressure;
        int base;
        int amp;
        logic [175:0] rv_free;
        logic [175:0] rv;
        logic signed [15:0] g;
        for (int it = 0; it < 2; it++) begin
            amp = (it == 0) ? 0 : int'($urandom_range(4, 9));
            for (int n = 0; n < N; n++) frame[n] = (int'($urandom_range(65535)) - 32768) >>> amp;
            model(N);
            rv_free = '0;
            for (int pass = 0; pass < 2; pass++) begin
                base = q_s.size();
                send_frame(N, (pass == 0) ? 0 : 40);
                wait_done(base, 40);
                nvec++;
                if (q_s.size() != base + 1) begin
                    nbad++; $display("FAIL rand%0d_pass%0d_done: got %0d pulses required 1", it, pass, q_s.size() - base);
                end else begin
                    rv = q_r[base];
                    nvec++; if (q_s[base] != exp_s) begin nbad++; $display("FAIL rand%0d_pass%0d_shift: got %0d required %0d", it, pass, q_s[base], exp_s); end
                    for (int k = 0; k < 11; k++) begin
                        g = rv[k*16 +: 16];
                        nvec++;
                        if (int'(g) != exp_r[k]) begin nbad++; $display("FAIL rand%0d_pass%0d_R%0d: got %0d required %0d", it, pass, k, g, exp_r[k]); end
                    end
                    if (pass == 0) rv_free = rv;
                    else begin
                        nvec++; if (rv !== rv_free) begin nbad++; $display("FAIL rand%0d_gap_vs_free: got %h required %h", it, rv, rv_free); end
                    end
                end
            end
        end
    endtask

    task automatic test_midframe_reset;
        int base;
        logic [175:0] rv;
        logic signed [15:0] g;
        base = q_s.size();
        for (int n = 0; n < N; n++) frame[n] = int'($urandom_range(65535)) - 32768;
        send_frame(80, 30);
        rst = 1'b0;
        @(negedge clk);
        nvec++; if (x_ready !== 1'b0) begin nbad++; $display("FAIL midrst_x_ready: got %b required 0", x_ready); end
        nvec++; if (r_all !== '0) begin nbad++; $display("FAIL midrst_R_cleared: got %h required 0", r_all); end
        nvec++; if (norm_shift !== 5'd0) begin nbad++; $display("FAIL midrst_shift: got %0d required 0", norm_shift); end
        @(negedge clk);
        rst = 1'b1;
        repeat (40) @(negedge clk);
        nvec++; if (q_s.size() != base) begin nbad++; $display("FAIL midrst_no_done: got %0d pulses required 0", q_s.size() - base); end
        for (int n = 0; n < N; n++) frame[n] = 0;
        frame[0] = 32767;
        model(N);
        base = q_s.size();
        send_frame(N, 30);
        wait_done(base, 40);
        nvec++;
        if (q_s.size() != base + 1) begin
            nbad++; $display("FAIL midrst_impulse_done: got %0d pulses required 1", q_s.size() - base);
        end else begin
            rv = q_r[base];
            nvec++; if (q_s[base] != 15) begin nbad++; $display("FAIL midrst_impulse_shift: got %0d required 15", q_s[base]); end
            for (int k = 0; k < 11; k++) begin
                g = rv[k*16 +: 16];
                nvec++;
                if (int'(g) != exp_r[k]) begin nbad++; $display("FAIL midrst_impulse_R%0d: got %0d required %0d", k, g, exp_r[k]); end
            end
        end
    endtask

    initial begin
        test_reset;
        test_constant;
        test_impulse;
        test_alternating;
        test_back_to_back;
        test_random_backpressure;
        test_midframe_reset;
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
        $finish;
    end

endmodule

// File: doc/autocorr.md
# autocorr

Frame-based autocorrelation engine for the LPC analysis path. Accepts a stream of signed Q15 speech samples, accumulates lags R[0..10] over a frame of N samples with one time-multiplexed MAC, block-normalises the result so R0 fits 16 bits, and presents R0..R10 with a one-cycle `done` pulse. `done` drives the `start` input of the Levinson-Durbin recursion block, and R0..R10 drive its R inputs directly.

## Interface
- `N`, 160: samples per frame; legal range 11..1023.
- `ACC_W`, 40: accumulator width; must be at least 32 + ceil(log2 N).
- `clk` input 1: single clock; everything is sampled on the rising edge.
- `rst` input 1: asynchronous, active-low reset.
- `x` input 16 signed: sample in Q15.
- `x_valid` input 1: `x` is valid.
- `x_ready` output 1: the block can accept a sample this cycle.
- `R0`..`R10` output 16 signed each: normalised autocorrelation lags.
- `norm_shift` output 5: right shift applied to every lag in the current frame.
- `done` output 1: one-cycle pulse; R outputs are new.

## Operation
- **Handshake.** A sample is accepted in a cycle where `x_valid && x_ready`. The producer must hold `x` stable while `x_valid && !x_ready`. No sample is dropped.
- **States.** ACCEPT, MAC, NORM, OUT.
- **ACCEPT.**
  - `x_ready`=1.
  - On accept: latch the sample as cur, then go to MAC with k=0.
- **MAC.**
  - Runs 11 cycles, k=0..10.
  - Each cycle: acc[k] += cur * dly[k]. dly[0]=cur, and dly[k] is the sample k positions earlier.
  - The product is 32-bit signed and is sign-extended to ACC_W.
  - After k=10: shift cur into the delay line (dly[1]=cur ... dly[10]=dly[9]) and increment the sample count.
  - If count==N, go to NORM; otherwise go to ACCEPT.
- **Frame start.** At the start of each frame (after reset, and in the cycle after OUT), the delay line, all accumulators and the count are zero. Lags with n<k therefore contribute zero: R[k] = sum over n=k..N-1 of x[n]x[n-k].
- **NORM** (1 cycle).
  - s = smallest value in 0..ACC_W-16 such that (acc[0] >>> s) <= 32767.
  - If acc[0]==0, s=0.
- **OUT** (1 cycle).
  - Rk = clamp(acc[k] >>> s, -32768, 32767). The shift truncates toward -inf.
  - `norm_shift`=s, `done`=1.
  - Clear the frame state and return to ACCEPT.
- **Holding outputs.** R0..R10 and `norm_shift` are held until the next OUT. They are unaffected by ongoing accumulation.
- **Reset.**
  - While `rst`=0, at any time including mid-frame: go to ACCEPT; clear all frame state (accumulators, delay line, count, cur).
  - Output values under reset: R0..R10=0, `norm_shift`=0, `done`=0, `x_ready`=0. `x_ready` goes to 1 in the first cycle after release.
  - A partial frame is discarded without a `done` pulse.

## Timing
- **Throughput.** One sample per 12 cycles: 1 ACCEPT cycle + 11 MAC cycles. `x_ready` is high only in ACCEPT, so with `x_valid` held high it shows a 1-in-12 pattern.
- **Latency.** For an accept at cycle T:
  - MAC runs in T+1..T+11.
  - For a non-final sample, `x_ready`=1 again at T+12.
  - For the final sample, NORM is at T+12 and OUT is at T+13.
  - `done`=1 and the new R/`norm_shift` values are registered at the end of T+13 and visible in T+14.
  - `x_ready`=1 in T+14, the same cycle `done` is visible.
- **Back-to-back frames.** The first sample of the next frame may be accepted in the cycle `done` is high. That sample belongs to the new frame.
- **Frame period.** Minimum 12N+2 cycles.

## Test plan
- **Reset.** Drive `rst`=0 for 3 cycles with `x_valid`=1 -> R0..R10=0, `norm_shift`=0, `done`=0, `x_ready`=0. `x_ready`=1 in the first cycle after release.
- **Constant input.** 160 samples of x=16384 -> one `done` pulse, `norm_shift`=21, R0=20480, R1=20352, Rk=(160-k)*128, R10=19200. `done` is visible 14 cycles after the last accept.
- **Impulse.** x[0]=32767 followed by 159 zeros -> `norm_shift`=15, R0=32766, R1..R10=0.
- **Alternating input.** x = +16384, -16384, ... for 160 samples -> `norm_shift`=21, R0=20480, R1=-20352, R2=20224, R10=19200.
- **Silence, then back-to-back frames.** First an all-zero frame -> R all 0, `norm_shift`=0. Then send the constant frame immediately, with the first sample accepted in the cycle `done` is high -> the second frame's results equal the constant-input scenario exactly.
- **Backpressure and mid-frame reset.**
  - With random `x_valid` gaps, the results match the gap-free case.
  - Asserting reset after 80 samples gives no `done`.
  - A following full impulse frame gives the impulse result, with no residue from the aborted frame.
